// File: rtl/store_aligner_buffer.sv
// Store-side byte-lane aligner with a small FIFO that drains aligned stores to data memory.
// Illegal or misaligned stores are dropped and flagged with a one-cycle st_err pulse.
module store_aligner_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   st_valid,
    output logic                   st_ready,
    input  logic [AW-1:0]          st_addr,
    input  logic [31:0]            st_data,
    input  logic [2:0]             st_func3,
    output logic                   st_err,
    output logic                   dm_req,
    input  logic                   dm_ready,
    output logic [AW-1:0]          dm_addr,
    output logic [31:0]            dm_wdata,
    output logic [3:0]             dm_wstrb,
    output logic                   sb_empty,
    output logic [$clog2(DEPTH):0] sb_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic        legal;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } align_t;

    function automatic align_t align_store(input logic [2:0]  func3,
                                           input logic [1:0]  ofs,
                                           input logic [31:0] data);
        align_t r;
        r = '0;
        case (func3)
            3'b000: begin
                r.legal = 1'b1;
                r.wstrb = 4'b0001 << ofs;
                r.wdata = {4{data[7:0]}};
            end
            3'b001: begin
                r.legal = ~ofs[0];
                r.wstrb = ofs[1] ? 4'b1100 : 4'b0011;
                r.wdata = {2{data[15:0]}};
            end
            3'b010: begin
                r.legal = (ofs == 2'b00);
                r.wstrb = 4'b1111;
                r.wdata = data;
            end
            default: r.legal = 1'b0;
        endcase
        return r;
    endfunction

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    align_t        algn_p0;
    logic          vld_p0;
    logic          enq;
    logic          deq;

    logic [AW-3:0] buf_addr_p1  [DEPTH];
    logic [31:0]   buf_wdata_p1 [DEPTH];
    logic [3:0]    buf_wstrb_p1 [DEPTH];

    // Stage p0: combinational alignment of the incoming request
    assign algn_p0 = align_store(st_func3, st_addr[1:0], st_data);
    assign vld_p0  = st_valid & st_ready;
    assign enq     = vld_p0 & algn_p0.legal;
    assign deq     = dm_req & dm_ready;

    // Stage p1: buffer storage (data only, no reset)
    always_ff @(posedge clk) begin
        if (enq) begin
            buf_addr_p1[wr_ptr]  <= st_addr[AW-1:2];
            buf_wdata_p1[wr_ptr] <= algn_p0.wdata;
            buf_wstrb_p1[wr_ptr] <= algn_p0.wstrb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            st_err <= 1'b0;
        end else begin
            st_err <= vld_p0 & ~algn_p0.legal;
            if (enq) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Head outputs are forced to zero while empty so unwritten storage never leaks out
    assign st_ready = (count != FULL);
    assign dm_req   = (count != '0);
    assign dm_addr  = dm_req ? {buf_addr_p1[rd_ptr], 2'b00} : '0;
    assign dm_wdata = dm_req ? buf_wdata_p1[rd_ptr] : '0;
    assign dm_wstrb = dm_req ? buf_wstrb_p1[rd_ptr] : '0;
    assign sb_empty = (count == '0);
    assign sb_count = count;

endmodule

// File: tb/tb_store_aligner_buffer.sv
// Bench for store_aligner_buffer: vector table of aligned stores plus multi-cycle
// sequences, with a queue scoreboard and a cycle model of occupancy and st_err.
module tb_store_aligner_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;

    logic                   clk;
    logic                   rst_n;
    logic                   st_valid;
    logic                   st_ready;
    logic [AW-1:0]          st_addr;
    logic [31:0]            st_data;
    logic [2:0]             st_func3;
    logic                   st_err;
    logic                   dm_req;
    logic                   dm_ready;
    logic [AW-1:0]          dm_addr;
    logic [31:0]            dm_wdata;
    logic [3:0]             dm_wstrb;
    logic                   sb_empty;
    logic [$clog2(DEPTH):0] sb_count;

    store_aligner_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .st_valid (st_valid),
        .st_ready (st_ready),
        .st_addr  (st_addr),
        .st_data  (st_data),
        .st_func3 (st_func3),
        .st_err   (st_err),
        .dm_req   (dm_req),
        .dm_ready (dm_ready),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_wstrb (dm_wstrb),
        .sb_empty (sb_empty),
        .sb_count (sb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        bit          legal;
        logic [31:0] eaddr;
        logic [31:0] ewdata;
        logic [3:0]  estrb;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    vec_t exp_q[$];
    bit   cur_legal = 1'b0;
    int   exp_cnt   = 0;
    bit   exp_err   = 1'b0;
    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                                input bit lg, input logic [31:0] ea, input logic [31:0] ed,
                                input logic [3:0] es);
        vec_t v;
        v.f3 = f3; v.addr = a; v.data = d; v.legal = lg;
        v.eaddr = ea; v.ewdata = ed; v.estrb = es;
        return v;
    endfunction

    function automatic vec_t mk_sw(input logic [31:0] a, input logic [31:0] d);
        return mk(3'b010, a, d, 1'b1, a, d, 4'b1111);
    endfunction

    // Called and returns at posedge+1; holds st_valid until the store is accepted
    task automatic send(input vec_t v);
        bit done = 1'b0;
        int n = 0;
        st_valid = 1'b1; st_func3 = v.f3; st_addr = v.addr; st_data = v.data;
        cur_legal = v.legal;
        while (!done) begin
            @(negedge clk);
            if (st_ready) begin
                done = 1'b1;
                if (v.legal) exp_q.push_back(v);
            end else if (++n > 50) begin
                chk("accept_timeout", 32'd0, 32'd1);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        st_valid = 1'b0;
        cur_legal = 1'b0;
    endtask

    task automatic wait_empty();
        bit done = 1'b0;
        int n = 0;
        while (!done) begin
            @(negedge clk);
            if (sb_empty) done = 1'b1;
            else if (++n > 50) begin
                chk("drain_timeout", 32'd0, 32'd1);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
    endtask

    // Cycle model: occupancy, flags, st_err pulse and head contents vs scoreboard
    always @(negedge clk) begin
        bit enq, deq;
        if (!rst_n) begin
            exp_cnt = 0;
            exp_err = 1'b0;
        end else begin
            chk("sb_count", 32'(sb_count), 32'(exp_cnt));
            chk("sb_empty", 32'(sb_empty), 32'(exp_cnt == 0));
            chk("st_ready", 32'(st_ready), 32'(exp_cnt != DEPTH));
            chk("dm_req", 32'(dm_req), 32'(exp_cnt != 0));
            chk("st_err", 32'(st_err), 32'(exp_err));
            if (dm_req && exp_cnt != 0 && exp_q.size() > 0) begin
                chk("dm_addr", dm_addr, exp_q[0].eaddr);
                chk("dm_wdata", dm_wdata, exp_q[0].ewdata);
                chk("dm_wstrb", 32'(dm_wstrb), 32'(exp_q[0].estrb));
                if (dm_ready) void'(exp_q.pop_front());
            end
            enq = st_valid && (exp_cnt != DEPTH) && cur_legal;
            deq = (exp_cnt != 0) && dm_ready;
            exp_err = st_valid && (exp_cnt != DEPTH) && !cur_legal;
            exp_cnt = exp_cnt + int'(enq) - int'(deq);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = mk(3'b000, 32'h0000_1003, 32'h1234_56AB, 1, 32'h0000_1000, 32'hABAB_ABAB, 4'b1000);
        tbl[1]  = mk(3'b001, 32'h0000_2002, 32'hFFFF_BEEF, 1, 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100);
        tbl[2]  = mk(3'b010, 32'h0000_2004, 32'hCAFE_F00D, 1, 32'h0000_2004, 32'hCAFE_F00D, 4'b1111);
        tbl[3]  = mk(3'b010, 32'h0000_3001, 32'h1111_1111, 0, 32'h0, 32'h0, 4'b0);
        tbl[4]  = mk(3'b001, 32'h0000_3003, 32'h2222_2222, 0, 32'h0, 32'h0, 4'b0);
        tbl[5]  = mk(3'b011, 32'h0000_3000, 32'h3333_3333, 0, 32'h0, 32'h0, 4'b0);
        tbl[6]  = mk(3'b000, 32'h0000_4000, 32'h0000_005A, 1, 32'h0000_4000, 32'h5A5A_5A5A, 4'b0001);
        tbl[7]  = mk(3'b000, 32'h0000_4001, 32'hFFFF_FF77, 1, 32'h0000_4000, 32'h7777_7777, 4'b0010);
        tbl[8]  = mk(3'b000, 32'h0000_4002, 32'h1122_3344, 1, 32'h0000_4000, 32'h4444_4444, 4'b0100);
        tbl[9]  = mk(3'b001, 32'h0000_4000, 32'hAAAA_1234, 1, 32'h0000_4000, 32'h1234_1234, 4'b0011);
        tbl[10] = mk(3'b001, 32'h0000_4001, 32'h5555_6666, 0, 32'h0, 32'h0, 4'b0);
        tbl[11] = mk(3'b100, 32'h0000_4000, 32'h7777_8888, 0, 32'h0, 32'h0, 4'b0);
        tbl[12] = mk(3'b010, 32'hFFFF_FFFC, 32'h0102_0304, 1, 32'hFFFF_FFFC, 32'h0102_0304, 4'b1111);

        rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_func3 = '0; dm_ready = 1'b0;
        #3;
        chk("rst_dm_req", 32'(dm_req), 32'd0);
        chk("rst_sb_empty", 32'(sb_empty), 32'd1);
        chk("rst_sb_count", 32'(sb_count), 32'd0);
        chk("rst_st_err", 32'(st_err), 32'd0);
        chk("rst_dm_addr", dm_addr, 32'd0);
        chk("rst_dm_wdata", dm_wdata, 32'd0);
        chk("rst_dm_wstrb", 32'(dm_wstrb), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_st_ready", 32'(st_ready), 32'd1);

        // Table: every vector drained immediately
        dm_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            send(tbl[i]);
            wait_empty();
        end

        // Fill to DEPTH with memory stalled; fifth store held until space frees
        dm_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++) send(mk_sw(32'h0000_5000 + 32'(4 * i), 32'hA000_0000 + 32'(i)));
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                chk("full_st_ready", 32'(st_ready), 32'd0);
                chk("full_sb_count", 32'(sb_count), 32'd4);
                dm_ready = 1'b1;
            end
        join
        wait_empty();

        // Simultaneous enqueue/dequeue at count 2, then a 3-cycle stall
        dm_ready = 1'b0;
        send(mk_sw(32'h0000_6000, 32'h6000_0001));
        send(mk_sw(32'h0000_6004, 32'h6000_0002));
        chk("pre_simul_count", 32'(sb_count), 32'd2);
        dm_ready = 1'b1;
        send(mk(3'b000, 32'h0000_6009, 32'h0000_00C3, 1, 32'h0000_6008, 32'hC3C3_C3C3, 4'b0010));
        dm_ready = 1'b0;
        chk("simul_count", 32'(sb_count), 32'd2);
        repeat (3) @(posedge clk);
        #1;
        dm_ready = 1'b1;
        wait_empty();

        // Async reset with entries pending and an st_err pulse in flight
        dm_ready = 1'b0;
        send(mk_sw(32'h0000_7000, 32'h7000_0001));
        send(mk_sw(32'h0000_7004, 32'h7000_0002));
        send(mk_sw(32'h0000_7008, 32'h7000_0003));
        send(mk(3'b010, 32'h0000_7002, 32'h0, 0, 32'h0, 32'h0, 4'b0));
        chk("pre_rst_st_err", 32'(st_err), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_dm_req", 32'(dm_req), 32'd0);
        chk("arst_st_err", 32'(st_err), 32'd0);
        chk("arst_sb_count", 32'(sb_count), 32'd0);
        chk("arst_sb_empty", 32'(sb_empty), 32'd1);
        chk("arst_dm_wstrb", 32'(dm_wstrb), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        dm_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        send(tbl[0]);
        wait_empty();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_aligner_buffer.md
Name: store_aligner_buffer

Overview:
- Store-side counterpart of the WB load sign-extension path: takes raw store requests (sb/sh/sw) from the MEM stage and aligns data into byte lanes.
- Generates per-byte write strobes and flags misaligned or illegal stores.
- Queues legal stores in a small FIFO and drains them to data memory over a valid/ready handshake, so the pipeline does not stall on memory write latency.

Parameters:
- DEPTH, 4, store buffer entries; power of two, >= 2.
- AW, 32, address width.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- st_valid  in  1  MEM stage presents a store.
- st_ready  out  1  buffer can accept a store this cycle.
- st_addr  in  AW  byte address of the store.
- st_data  in  32  rs2 value, unaligned (data in low bits).
- st_func3  in  3  RV32I store func3: 000 sb, 001 sh, 010 sw.
- st_err  out  1  registered one-cycle pulse: last accepted store was misaligned or illegal.
- dm_req  out  1  head entry valid toward data memory.
- dm_ready  in  1  data memory accepts the write this cycle.
- dm_addr  out  AW  word-aligned address ({addr[AW-1:2],2'b00}).
- dm_wdata  out  32  lane-aligned write data.
- dm_wstrb  out  4  byte write enables; bit i = byte lane i.
- sb_empty  out  1  no stores pending; used by fence/load-ordering logic.
- sb_count  out  clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (async, rst_n low):
  - rd/wr pointers = 0, count = 0.
  - st_err = 0, dm_req = 0, dm_addr/dm_wdata/dm_wstrb = 0.
  - sb_empty = 1, st_ready = 1 once rst_n is high.
  - Reset mid-operation discards all buffered stores; no partial write is issued.
- Alignment (combinational on input, o = st_addr[1:0]):
  - sb: wstrb = 4'b0001 << o; wdata = {4{st_data[7:0]}}; always legal.
  - sh: legal only if o[0] = 0; wstrb = o[1] ? 4'b1100 : 4'b0011; wdata = {2{st_data[15:0]}}.
  - sw: legal only if o = 0; wstrb = 4'b1111; wdata = st_data.
  - Any other func3: illegal.
- Accept: st_ready = (count != DEPTH). It does not depend on a same-cycle dequeue, so there is no combinational path from dm_ready to st_ready.
- Enqueue: on st_valid & st_ready & legal, write {word addr, wdata, wstrb} at wr_ptr, then wr_ptr++ (wraps modulo DEPTH).
- Error: on st_valid & st_ready & !legal, nothing is enqueued and st_err = 1 the next cycle. Otherwise st_err = 0 next cycle.
- Drain: dm_req = (count != 0); dm_* driven from the entry at rd_ptr.
  - On dm_req & dm_ready, rd_ptr++ (wraps).
  - While dm_req = 1 and dm_ready = 0, dm_addr/dm_wdata/dm_wstrb hold stable.
- Latency: a store accepted in cycle N appears on dm_* in cycle N+1 at the earliest. There is no empty-bypass path.
- Count update:
  - +1 on enqueue only.
  - −1 on dequeue only.
  - Unchanged on simultaneous enqueue and dequeue, including at count = DEPTH−1 and count = 1.
- Ordering: strict FIFO; stores reach memory in acceptance order.
- sb_empty = (count == 0); sb_count = count. Both are registered-state derived and glitch-free.

Test Plan:
- sb, st_addr = 0x0000_1003, st_data = 0x1234_56AB, dm_ready = 1 -> next cycle dm_req = 1, dm_addr = 0x0000_1000, dm_wstrb = 4'b1000, dm_wdata = 0xABABABAB; sb_empty returns to 1 one cycle later.
- sh at 0x2002 with data 0xFFFF_BEEF -> dm_wstrb = 4'b1100, dm_wdata = 0xBEEFBEEF. sw at 0x2004 -> wstrb = 4'b1111, data unchanged.
- sw at 0x3001, sh at 0x3003, func3 = 3'b011 -> each yields a one-cycle st_err pulse; sb_count stays 0; dm_req never asserts.
- DEPTH = 4, dm_ready = 0, five back-to-back stores -> st_ready drops after the 4th is accepted, sb_count = 4, and the 5th is held. Raising dm_ready drains entries in order, and the 5th is accepted the cycle after count < 4.
- At count = 2, st_valid and dm_ready both high -> count remains 2, and head/tail contents are correct. Hold dm_ready low for 3 cycles -> dm_* stable.
- Assert rst_n low with 3 entries pending and dm_req high -> dm_req, st_err and sb_count go to 0 immediately (async). No write is issued after release.
